rx_engine_stream: RTL and testbench
===================================

# rx_engine_stream

Receive-side counterpart of the streaming MAC transmit engine. Takes GMII bytes from the PHY interface, strips the preamble and SFD, filters on destination MAC and ethertype, and checks the CRC-32 FCS. It writes the payload only (no header, no FCS) into a 10-bit receive FIFO; the end-of-frame word carries a good/bad status.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- my_mac_addr  in  48  station address; byte 0 on the wire is bits [47:40].
- ethertype  in  16  accepted ethertype; first wire byte is bits [15:8].
- promisc  in  1  accept any destination MAC.
- jumboframes  in  1  max payload 9000 when 1, 1500 when 0.
- int_rx_din  in  8  GMII receive data.
- int_rx_dv  in  1  GMII data valid.
- int_rx_er  in  1  GMII receive error.
- rxff_din  out  10  {bad, eof, data[7:0]}.
- rxff_wren  out  1  FIFO write strobe.
- rxff_full  in  1  FIFO full; no write is issued while high.
- rx_count  out  32  good frames delivered.
- rx_err_count  out  32  frames ending with bad=1, or dropped after acceptance.
- debug  out  4  current state code.

## Operation
- GMII inputs are registered once; the FSM acts on the registered values.
- States: IDLE=0, PREAMBLE=1, HEADER=2, DATA=3, DISCARD=4, ERRWAIT=5, ABORT=6.
- **IDLE:** moves to PREAMBLE on dv=1 with byte 0x55. dv with any other byte goes to DISCARD.
- **PREAMBLE:** moves to HEADER on 0xD5. Goes to DISCARD on:
  - a byte other than 0x55;
  - dv low;
  - more than 7 bytes of 0x55.
- **CRC:**
  - Standard CRC-32 (0x04C11DB7), reflected, initialised to 0xFFFFFFFF at SFD.
  - Covers every byte from the first destination-MAC byte through the last FCS byte.
  - Frame CRC is good iff the register equals 32'hDEBB20E3 when dv falls.
- **HEADER:** 14 bytes.
  - Destination matches when it equals my_mac_addr, equals FF:FF:FF:FF:FF:FF, or promisc=1.
  - Type field must equal ethertype.
  - On mismatch at byte 14: go to DISCARD. No FIFO write ever occurs for filtered frames.
- **DATA:**
  - Payload bytes pass through a 5-byte delay line. Byte k is written when byte k+5 has been received, so the FCS never reaches the FIFO.
  - On dv low, the oldest byte in the line is written with eof=1 and bad as below. Then go to IDLE.
- **bad=1 when any of:**
  - CRC fails;
  - int_rx_er was seen at any point after SFD;
  - 14+payload+4 < 64 bytes.
- **Empty payload:** with fewer than one payload byte, a single word {1,1,8'h00} is written instead.
- **Oversize:** payload beyond the max (1500/9000) goes to ERRWAIT.
  - Excess bytes are not written.
  - On dv low, {1,1,8'h00} is written.
- **FIFO full:** rxff_full=1 when a payload write is due goes to ABORT.
  - Further bytes are discarded.
  - After dv low, {1,1,8'h00} is written on the first cycle rxff_full=0. Then go to IDLE.
  - A frame starting while in ABORT is ignored in full; it increments rx_err_count once at its end.
- **DISCARD / ERRWAIT:** wait for dv low, then IDLE. ERRWAIT behaves as above.
- **Counters:**
  - rx_count increments on each eof write with bad=0.
  - rx_err_count increments on each eof write with bad=1 and each frame ignored during ABORT.
  - Both wrap mod 2^32.
- **Payload counter:** 14 bits, saturating. It does not wrap.

## Timing
- Reset values:
  - state = IDLE;
  - rxff_wren = 0;
  - rxff_din = 0;
  - rx_count = rx_err_count = 0;
  - debug = 0;
  - delay line and CRC register cleared.
- rxff_din and rxff_wren are registered outputs.
- The eof write is asserted exactly 2 clk cycles after the first edge that samples int_rx_dv=0 (unless ABORT is waiting on full).
- The first payload write occurs 2 cycles after the edge sampling payload byte 5 (0-based 5th byte after type field).
- Counters update on the cycle after the eof write.
- dv dropping in PREAMBLE or HEADER gives no write and no count change.
- Reset mid-frame: the FSM goes to IDLE immediately and the remainder of the frame is ignored until dv drops and a new preamble arrives (DISCARD behaviour).
- Back-to-back frames with a 1-cycle dv gap are accepted.

## Test plan
- **Valid 46-byte payload** to my_mac, good FCS, jumbo=0:
  - 46 writes, last {0,1,byte45};
  - rx_count=1, rx_err_count=0;
  - no FCS bytes written.
- **Wrong destination MAC**, promisc=0: zero writes, counters unchanged. Repeat with promisc=1: 46 writes.
- **Corrupted FCS:** same frame with one payload bit flipped. 46 writes, last has bad=1; rx_err_count=1.
- **int_rx_er pulsed** on payload byte 10: frame delivered, eof word bad=1.
- **1501-byte payload**, jumbo=0: exactly 1500 data writes, then {1,1,00}; rx_err_count=1.
  - Same frame with jumbo=1: good, 1501 writes, rx_count=1.
- **rxff_full raised** at payload byte 20 and released after dv falls:
  - no writes while full;
  - one {1,1,00} write when full drops;
  - next frame received normally.

Source files
------------

// File: rtl/rx_engine_stream_if.sv
// GMII receive side plus receive-FIFO write port of the MAC receive engine.
// The engine takes the slave view; the PHY/FIFO environment takes the master view.
interface rx_engine_stream_if;
    logic [7:0] int_rx_din;
    logic       int_rx_dv;
    logic       int_rx_er;
    logic [9:0] rxff_din;
    logic       rxff_wren;
    logic       rxff_full;

    modport slave (
        input  int_rx_din, int_rx_dv, int_rx_er, rxff_full,
        output rxff_din, rxff_wren
    );

    modport master (
        output int_rx_din, int_rx_dv, int_rx_er, rxff_full,
        input  rxff_din, rxff_wren
    );
endinterface

// File: rtl/rx_engine_stream.sv
// Streaming MAC receive engine: strips preamble/SFD, filters on destination
// MAC and ethertype, checks the CRC-32 FCS and writes payload bytes (with an
// end-of-frame good/bad status word) into a 10-bit receive FIFO.
module rx_engine_stream (
    input  logic                clk,
    input  logic                reset_n,
    rx_engine_stream_if.slave   bus,
    input  logic [47:0]         my_mac_addr,
    input  logic [15:0]         ethertype,
    input  logic                promisc,
    input  logic                jumboframes,
    output logic [31:0]         rx_count,
    output logic [31:0]         rx_err_count,
    output logic [3:0]          debug
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_HEADER   = 4'd2,
        S_DATA     = 4'd3,
        S_DISCARD  = 4'd4,
        S_ERRWAIT  = 4'd5,
        S_ABORT    = 4'd6
    } state_t;

    localparam logic [9:0]  ABORT_WORD = 10'h300;   // {bad=1, eof=1, 8'h00}
    localparam logic [31:0] CRC_RESID  = 32'hDEBB20E3;

    // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    state_t      r_state;
    logic [7:0]  r_din;
    logic        r_dv;
    logic        r_er;
    logic        r_dv_d;
    logic [2:0]  r_pre_cnt;
    logic [3:0]  r_hcnt;
    logic        r_mac_ok;
    logic        r_bc_ok;
    logic        r_type_ok;
    logic [31:0] r_crc;
    logic        r_er_seen;
    logic [13:0] r_pcnt;
    logic [7:0]  r_dl [0:4];
    logic [2:0]  r_fill;
    logic [9:0]  r_wdata;
    logic        r_wren;
    logic        r_dvlow;
    logic        r_ign;
    logic        r_ign_pulse;
    logic [31:0] r_rx_count;
    logic [31:0] r_err_count;

    logic [31:0] w_crc_next;
    logic [13:0] w_max_idx;
    logic [47:0] w_mac_sh;
    logic        w_type_ok_now;
    logic        w_dst_ok;
    logic        w_bad;
    logic        w_oversize;
    logic [1:0]  w_err_inc;

    assign w_crc_next    = crc32_byte(r_crc, r_din);
    // Received-byte index (FCS included) at which the payload exceeds its limit.
    assign w_max_idx     = jumboframes ? 14'd9005 : 14'd1505;
    assign w_mac_sh      = my_mac_addr << {r_hcnt, 3'b000};
    assign w_type_ok_now = r_type_ok && (r_din == ethertype[7:0]);
    assign w_dst_ok      = r_mac_ok || r_bc_ok || promisc;
    assign w_oversize    = (r_pcnt >= w_max_idx);
    // Minimum frame 64 bytes: 14 header + payload + 4 FCS, so payload+FCS < 50 is short.
    assign w_bad         = (r_crc != CRC_RESID) || r_er_seen || (r_pcnt < 14'd50);
    assign w_err_inc     = {1'b0, r_wren & r_wdata[8] & r_wdata[9]} + {1'b0, r_ign_pulse};

    assign bus.rxff_din  = r_wdata;
    assign bus.rxff_wren = r_wren;
    assign rx_count      = r_rx_count;
    assign rx_err_count  = r_err_count;
    assign debug         = r_state;

    // Register the GMII inputs once; r_dv_d resets high so a frame already in
    // flight when reset releases is treated as a continuation and discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_din  <= 8'h00;
            r_dv   <= 1'b0;
            r_er   <= 1'b0;
            r_dv_d <= 1'b1;
        end else begin
            r_din  <= bus.int_rx_din;
            r_dv   <= bus.int_rx_dv;
            r_er   <= bus.int_rx_er;
            r_dv_d <= r_dv;
        end
    end

    // Receive FSM: framing, filtering, CRC, delay line and FIFO write generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pre_cnt   <= 3'd0;
            r_hcnt      <= 4'd0;
            r_mac_ok    <= 1'b0;
            r_bc_ok     <= 1'b0;
            r_type_ok   <= 1'b0;
            r_crc       <= 32'h0;
            r_er_seen   <= 1'b0;
            r_pcnt      <= 14'd0;
            r_fill      <= 3'd0;
            r_wdata     <= 10'h000;
            r_wren      <= 1'b0;
            r_dvlow     <= 1'b0;
            r_ign       <= 1'b0;
            r_ign_pulse <= 1'b0;
            for (int i = 0; i < 5; i++) r_dl[i] <= 8'h00;
        end else begin
            r_wren      <= 1'b0;
            r_ign_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_dv) begin
                        if (r_din == 8'h55 && !r_dv_d) begin
                            r_state   <= S_PREAMBLE;
                            r_pre_cnt <= 3'd1;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!r_dv) begin
                        r_state <= S_DISCARD;
                    end else if (r_din == 8'hD5) begin
                        r_state   <= S_HEADER;
                        r_crc     <= 32'hFFFFFFFF;
                        r_hcnt    <= 4'd0;
                        r_mac_ok  <= 1'b1;
                        r_bc_ok   <= 1'b1;
                        r_type_ok <= 1'b0;
                        r_er_seen <= 1'b0;
                        r_pcnt    <= 14'd0;
                        r_fill    <= 3'd0;
                    end else if (r_din == 8'h55 && r_pre_cnt != 3'd7) begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                    end else begin
                        r_state <= S_DISCARD;
                    end
                end
                S_HEADER: begin
                    if (!r_dv) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_crc     <= w_crc_next;
                        r_er_seen <= r_er_seen | r_er;
                        r_hcnt    <= r_hcnt + 4'd1;
                        if (r_hcnt < 4'd6) begin
                            r_mac_ok <= r_mac_ok && (r_din == w_mac_sh[47:40]);
                            r_bc_ok  <= r_bc_ok && (r_din == 8'hFF);
                        end
                        if (r_hcnt == 4'd12) r_type_ok <= (r_din == ethertype[15:8]);
                        if (r_hcnt == 4'd13) begin
                            r_state <= (w_dst_ok && w_type_ok_now) ? S_DATA : S_DISCARD;
                        end
                    end
                end
                S_DATA: begin
                    if (r_dv) begin
                        r_crc     <= w_crc_next;
                        r_er_seen <= r_er_seen | r_er;
                        r_pcnt    <= (r_pcnt == 14'h3FFF) ? r_pcnt : r_pcnt + 14'd1;
                        r_dl[0]   <= r_din;
                        for (int i = 1; i < 5; i++) r_dl[i] <= r_dl[i-1];
                        if (r_fill != 3'd5) begin
                            r_fill <= r_fill + 3'd1;
                        end else if (w_oversize) begin
                            r_state <= S_ERRWAIT;
                        end else if (bus.rxff_full) begin
                            r_state <= S_ABORT;
                            r_dvlow <= 1'b0;
                        end else begin
                            r_wdata <= {2'b00, r_dl[4]};
                            r_wren  <= 1'b1;
                        end
                    end else if (bus.rxff_full) begin
                        r_state <= S_ABORT;
                        r_dvlow <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_wren  <= 1'b1;
                        r_wdata <= (r_fill != 3'd5 || w_oversize) ? ABORT_WORD
                                                                  : {w_bad, 1'b1, r_dl[4]};
                    end
                end
                S_ERRWAIT: begin
                    if (!r_dv) begin
                        if (bus.rxff_full) begin
                            r_state <= S_ABORT;
                            r_dvlow <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_wdata <= ABORT_WORD;
                            r_wren  <= 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    if (!r_dvlow) begin
                        if (!r_dv) r_dvlow <= 1'b1;
                    end else if (!bus.rxff_full) begin
                        r_wdata <= ABORT_WORD;
                        r_wren  <= 1'b1;
                        r_state <= r_ign ? S_DISCARD : S_IDLE;
                    end else if (r_dv && !r_ign) begin
                        r_ign <= 1'b1;
                    end else if (!r_dv && r_ign) begin
                        r_ign       <= 1'b0;
                        r_ign_pulse <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (!r_dv) begin
                        r_state <= S_IDLE;
                        if (r_ign) begin
                            r_ign       <= 1'b0;
                            r_ign_pulse <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Frame statistics, updated the cycle after each end-of-frame write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_count  <= 32'd0;
            r_err_count <= 32'd0;
        end else begin
            if (r_wren && r_wdata[8] && !r_wdata[9]) r_rx_count <= r_rx_count + 32'd1;
            r_err_count <= r_err_count + {30'd0, w_err_inc};
        end
    end

endmodule

// File: tb/tb_rx_engine_stream.sv
// Directed bench for rx_engine_stream: builds Ethernet frames with a
// bench-computed FCS and checks FIFO writes and counters against them.
module tb_rx_engine_stream;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] my_mac = 48'h02_11_22_33_44_55;
    logic [15:0] etype  = 16'h88B5;
    logic        promisc = 1'b0;
    logic        jumbo = 1'b0;
    logic [31:0] rx_count;
    logic [31:0] rx_err_count;
    logic [3:0]  debug;

    always #5 clk = ~clk;

    rx_engine_stream_if bus();

    rx_engine_stream dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .my_mac_addr  (my_mac),
        .ethertype    (etype),
        .promisc      (promisc),
        .jumboframes  (jumbo),
        .rx_count     (rx_count),
        .rx_err_count (rx_err_count),
        .debug        (debug)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] frm [$];
    logic [7:0] pay [$];
    logic [9:0] cap [$];
    int         full_viol = 0;
    logic       full_prev = 1'b0;
    longint     t_eof = 0;
    longint     t_dv0 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.rxff_wren) begin
            cap.push_back(bus.rxff_din);
            if (full_prev) full_viol <= full_viol + 1;
            if (bus.rxff_din[8]) t_eof <= $time + 5;
        end
        full_prev <= bus.rxff_full;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic make_frame(input logic [47:0] dst, input int plen);
        logic [31:0] crc;
        frm.delete();
        pay.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'hA0 + i));
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        for (int i = 0; i < plen; i++) begin
            pay.push_back(8'(i * 7 + 3));
            frm.push_back(8'(i * 7 + 3));
        end
        crc = 32'hFFFFFFFF;
        foreach (frm[i]) crc = crc_upd(crc, frm[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
    endtask

    task automatic drive(input logic [7:0] b, input logic er);
        @(posedge clk); #1;
        bus.int_rx_dv  = 1'b1;
        bus.int_rx_din = b;
        bus.int_rx_er  = er;
    endtask

    // Send preamble, SFD and frm; er_idx / full_idx index into frm (-1 = none).
    task automatic run_frame(input int er_idx, input int full_idx);
        cap.delete();
        full_viol = 0;
        t_eof = 0;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        foreach (frm[i]) begin
            drive(frm[i], i == er_idx);
            if (i == full_idx) bus.rxff_full = 1'b1;
        end
        @(posedge clk); #1;
        bus.int_rx_dv  = 1'b0;
        bus.int_rx_din = 8'h00;
        bus.int_rx_er  = 1'b0;
        t_dv0 = $time + 9;
        if (full_idx >= 0) begin
            repeat (6) @(posedge clk);
            #1 bus.rxff_full = 1'b0;
        end
        repeat (12) @(posedge clk);
    endtask

    function automatic int data_mism(input int n);
        int m = 0;
        for (int i = 0; i < n; i++)
            if (i >= cap.size() || cap[i] !== {2'b00, pay[i]}) m++;
        return m;
    endfunction

    initial begin
        bus.int_rx_dv  = 1'b0;
        bus.int_rx_din = 8'h00;
        bus.int_rx_er  = 1'b0;
        bus.rxff_full  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wren", 64'(bus.rxff_wren), 64'd0);
        check("rst_din", 64'(bus.rxff_din), 64'd0);
        check("rst_rx_count", 64'(rx_count), 64'd0);
        check("rst_err_count", 64'(rx_err_count), 64'd0);
        check("rst_debug", 64'(debug), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Good 46-byte payload.
        make_frame(my_mac, 46);
        run_frame(-1, -1);
        check("good_writes", 64'(cap.size()), 64'd46);
        check("good_data", 64'(data_mism(45)), 64'd0);
        check("good_eof", 64'(cap[cap.size()-1]), 64'({2'b01, pay[45]}));
        check("good_eof_lat", 64'(t_eof - t_dv0), 64'd20);
        check("good_rx_count", 64'(rx_count), 64'd1);
        check("good_err_count", 64'(rx_err_count), 64'd0);

        // Wrong destination, filtered then accepted in promiscuous mode.
        make_frame(48'h02_11_22_33_44_66, 46);
        run_frame(-1, -1);
        check("wrongmac_writes", 64'(cap.size()), 64'd0);
        check("wrongmac_rx_count", 64'(rx_count), 64'd1);
        check("wrongmac_err_count", 64'(rx_err_count), 64'd0);
        promisc = 1'b1;
        run_frame(-1, -1);
        check("promisc_writes", 64'(cap.size()), 64'd46);
        check("promisc_rx_count", 64'(rx_count), 64'd2);
        promisc = 1'b0;

        // One payload bit flipped after the FCS was computed.
        make_frame(my_mac, 46);
        frm[17] = frm[17] ^ 8'h01;
        pay[3]  = pay[3] ^ 8'h01;
        run_frame(-1, -1);
        check("badfcs_writes", 64'(cap.size()), 64'd46);
        check("badfcs_data", 64'(data_mism(45)), 64'd0);
        check("badfcs_eof", 64'(cap[cap.size()-1]), 64'({2'b11, pay[45]}));
        check("badfcs_err_count", 64'(rx_err_count), 64'd1);

        // int_rx_er on payload byte 10.
        make_frame(my_mac, 46);
        run_frame(24, -1);
        check("rxer_writes", 64'(cap.size()), 64'd46);
        check("rxer_eof", 64'(cap[cap.size()-1]), 64'({2'b11, pay[45]}));
        check("rxer_err_count", 64'(rx_err_count), 64'd2);

        // Runt: 10-byte payload, good FCS.
        make_frame(my_mac, 10);
        run_frame(-1, -1);
        check("runt_writes", 64'(cap.size()), 64'd10);
        check("runt_eof", 64'(cap[cap.size()-1]), 64'({2'b11, pay[9]}));
        check("runt_err_count", 64'(rx_err_count), 64'd3);

        // 1501-byte payload, standard then jumbo.
        make_frame(my_mac, 1501);
        run_frame(-1, -1);
        check("over_writes", 64'(cap.size()), 64'd1501);
        check("over_data", 64'(data_mism(1500)), 64'd0);
        check("over_eof", 64'(cap[cap.size()-1]), 64'h300);
        check("over_err_count", 64'(rx_err_count), 64'd4);
        jumbo = 1'b1;
        run_frame(-1, -1);
        check("jumbo_writes", 64'(cap.size()), 64'd1501);
        check("jumbo_eof", 64'(cap[cap.size()-1]), 64'({2'b01, pay[1500]}));
        check("jumbo_rx_count", 64'(rx_count), 64'd3);
        jumbo = 1'b0;

        // FIFO full from payload byte 20 until after dv falls.
        make_frame(my_mac, 46);
        run_frame(34, 34);
        check("full_viol", 64'(full_viol), 64'd0);
        check("full_eof", 64'(cap[cap.size()-1]), 64'h300);
        check("full_short", 64'(cap.size() < 46), 64'd1);
        check("full_err_count", 64'(rx_err_count), 64'd5);
        check("full_rx_count", 64'(rx_count), 64'd3);

        // Normal frame after the abort.
        run_frame(-1, -1);
        check("after_writes", 64'(cap.size()), 64'd46);
        check("after_eof", 64'(cap[cap.size()-1]), 64'({2'b01, pay[45]}));
        check("after_rx_count", 64'(rx_count), 64'd4);
        check("after_err_count", 64'(rx_err_count), 64'd5);
        check("end_debug", 64'(debug), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
